// File: rtl/cr_huf_comp_st_ism_arb_pkg.sv
// Shared types and constants for the ISM record arbiter.
package cr_huf_comp_st_ism_arb_pkg;

  localparam int unsigned ST_ISM_MAX_CH   = 8;
  localparam int unsigned ST_ISM_MAX_CH_W = 3;
  localparam int unsigned ST_ISM_DAT_W    = 32;

  // Channel-tagged ISM record as seen on the merged stream
  typedef struct packed {
    logic [ST_ISM_MAX_CH_W-1:0] ch;
    logic [ST_ISM_DAT_W-1:0]    data;
  } st_ism_rec_t;

  // Channel-index width; never narrower than one bit
  function automatic int unsigned ch_w_f(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/cr_huf_comp_st_ism_arb_if.sv
// Builder-side record handshakes plus the merged downstream ISM stream.
interface cr_huf_comp_st_ism_arb_if
  import cr_huf_comp_st_ism_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DAT_W  = 32
);
  localparam int unsigned CH_W = ch_w_f(NUM_CH);

  logic [NUM_CH-1:0]       st_bl_ism_vld;
  logic [NUM_CH*DAT_W-1:0] st_bl_ism_data;
  logic [NUM_CH-1:0]       st_ism_rdy;
  logic                    ism_rdy;
  logic                    ism_vld;
  logic [DAT_W-1:0]        ism_data;
  logic [CH_W-1:0]         ism_ch;

  modport slave (
    input  st_bl_ism_vld, st_bl_ism_data, ism_rdy,
    output st_ism_rdy, ism_vld, ism_data, ism_ch
  );

  modport master (
    output st_bl_ism_vld, st_bl_ism_data, ism_rdy,
    input  st_ism_rdy, ism_vld, ism_data, ism_ch
  );

endinterface

// File: rtl/cr_huf_comp_st_ism_arb_fifo.sv
// Per-channel record FIFO with show-ahead read (head visible while non-empty).
module cr_huf_comp_st_ism_arb_fifo #(
  parameter int unsigned DAT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DAT_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [DAT_W-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DAT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: flush dominates push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/cr_huf_comp_st_ism_arb.sv
// Merges per-builder ISM records round-robin onto one tagged stream and
// keeps per-channel saturating rebuild / rebuild-failed counters.
module cr_huf_comp_st_ism_arb
  import cr_huf_comp_st_ism_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DAT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_ism_on_i,
  cr_huf_comp_st_ism_arb_if.slave bus,
  input  logic [NUM_CH-1:0]       st_dbg_cntr_rebuild_i,
  input  logic [NUM_CH-1:0]       st_dbg_cntr_rebuild_failed_i,
  input  logic                    cntr_clr_i,
  output logic [NUM_CH*CNT_W-1:0] cntr_rebuild_o,
  output logic [NUM_CH*CNT_W-1:0] cntr_rebuild_failed_o
);

  localparam int unsigned CH_W = ch_w_f(NUM_CH);

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic [DAT_W-1:0]  fifo_rdata [NUM_CH];
  logic [NUM_CH-1:0] st_ism_rdy_c;

  logic              ism_vld_q, ism_vld_d;
  logic [DAT_W-1:0]  ism_data_q, ism_data_d;
  logic [CH_W-1:0]   ism_ch_q, ism_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              holding;

  // Builders are never stalled while ISM is off
  assign st_ism_rdy_c   = sw_ism_on_i ? ~fifo_full : '1;
  assign fifo_push      = bus.st_bl_ism_vld & st_ism_rdy_c & {NUM_CH{sw_ism_on_i}};
  assign bus.st_ism_rdy = st_ism_rdy_c;

  // One record FIFO per builder channel
  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    cr_huf_comp_st_ism_arb_fifo #(
      .DAT_W      (DAT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (!sw_ism_on_i),
      .push_i      (fifo_push[g]),
      .push_data_i (bus.st_bl_ism_data[g*DAT_W +: DAT_W]),
      .pop_i       (fifo_pop[g]),
      .pop_data_o  (fifo_rdata[g]),
      .full_o      (fifo_full[g]),
      .empty_o     (fifo_empty[g])
    );
  end

  assign holding = ism_vld_q && !bus.ism_rdy;

  // Round-robin pick from the channel after the last grant, loading the output register
  always_comb begin
    logic            found;
    logic [CH_W-1:0] sel;
    fifo_pop     = '0;
    ism_vld_d    = 1'b0;
    ism_data_d   = ism_data_q;
    ism_ch_d     = ism_ch_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    sel          = '0;
    if (!sw_ism_on_i) begin
      ism_data_d = '0;
      ism_ch_d   = '0;
    end else if (holding) begin
      ism_vld_d = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        sel = CH_W'((32'(last_grant_q) + i) % NUM_CH);
        if (!found && !fifo_empty[sel]) begin
          found          = 1'b1;
          fifo_pop[sel]  = 1'b1;
          ism_vld_d      = 1'b1;
          ism_data_d     = fifo_rdata[sel];
          ism_ch_d       = sel;
          last_grant_d   = sel;
        end
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ism_vld_q    <= 1'b0;
      ism_data_q   <= '0;
      ism_ch_q     <= '0;
      last_grant_q <= '0;
    end else begin
      ism_vld_q    <= ism_vld_d;
      ism_data_q   <= ism_data_d;
      ism_ch_q     <= ism_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.ism_vld  = ism_vld_q;
  assign bus.ism_data = ism_data_q;
  assign bus.ism_ch   = ism_ch_q;

  // Per-channel saturating debug counters; clear beats a coincident event
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cntr
    logic [CNT_W-1:0] rb_q, rb_d;
    logic [CNT_W-1:0] rbf_q, rbf_d;

    // Counter next-state
    always_comb begin
      rb_d  = rb_q;
      rbf_d = rbf_q;
      if (cntr_clr_i) begin
        rb_d  = '0;
        rbf_d = '0;
      end else begin
        if (st_dbg_cntr_rebuild_i[g] && (rb_q != '1))         rb_d  = rb_q + CNT_W'(1);
        if (st_dbg_cntr_rebuild_failed_i[g] && (rbf_q != '1)) rbf_d = rbf_q + CNT_W'(1);
      end
    end

    // Counter registers
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rb_q  <= '0;
        rbf_q <= '0;
      end else begin
        rb_q  <= rb_d;
        rbf_q <= rbf_d;
      end
    end

    assign cntr_rebuild_o[g*CNT_W +: CNT_W]        = rb_q;
    assign cntr_rebuild_failed_o[g*CNT_W +: CNT_W] = rbf_q;
  end

endmodule
